zesal_node_ctrl: RTL and testbench

Sequencer that lets one requester run lookup/insert/delete on a single Zesal node. It accepts one request at a time over a valid/ready handshake and turns each into the node's command sequence: Reset, Find, ShiftUp/ShiftDown, Write. It tracks node occupancy and returns one status/data response per request. It sits between the tree-walk logic and the Zesal node datapath.

---
 rtl/zesal_pkg.sv | 38 +++
 rtl/zesal_node_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_zesal_node_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/zesal_pkg.sv
// Shared definitions for the Zesal node controller: node command codes,
// request/response encodings and the sequencer state set.
package zesal_pkg;

  localparam int CMD_IDLE       = 0;
  localparam int CMD_RESET      = 1;
  localparam int CMD_FIND       = 2;
  localparam int CMD_FOUND      = 3;
  localparam int CMD_SHIFT_UP   = 4;
  localparam int CMD_SHIFT_DOWN = 5;
  localparam int CMD_WRITE      = 6;

  typedef enum logic [1:0] {
    OP_LOOKUP = 2'd0,
    OP_INSERT = 2'd1,
    OP_DELETE = 2'd2,
    OP_RSVD   = 2'd3
  } req_op_e;

  typedef enum logic [2:0] {
    RSP_OK        = 3'd0,
    RSP_NOT_FOUND = 3'd1,
    RSP_FULL      = 3'd2,
    RSP_UPDATED   = 3'd3,
    RSP_BADOP     = 3'd4
  } rsp_status_e;

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_IDLE   = 3'd1,
    S_WAIT   = 3'd2,
    S_DECIDE = 3'd3,
    S_SHIFT  = 3'd4,
    S_WRITE  = 3'd5,
    S_RESP   = 3'd6
  } ctrl_state_e;

endpackage

// File: rtl/zesal_node_ctrl.sv
// Sequencer turning lookup/insert/delete requests into Zesal node command
// sequences, tracking occupancy and returning one response per request.
module zesal_node_ctrl
  import zesal_pkg::*;
#(
  parameter int KEYS_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int INDEX_BITS    = 8,
  parameter int NODE_CMD_BITS = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [1:0]               req_op,
  input  logic [KEYS_BITS-1:0]     req_key,
  input  logic [DATA_BITS-1:0]     req_data,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [2:0]               rsp_status,
  output logic [DATA_BITS-1:0]     rsp_data,
  output logic [NODE_CMD_BITS-1:0] node_cmd,
  output logic [KEYS_BITS-1:0]     node_key,
  output logic [INDEX_BITS-1:0]    node_pos,
  output logic [DATA_BITS-1:0]     node_data,
  input  logic                     node_found,
  input  logic [INDEX_BITS-1:0]    node_hit_pos,
  input  logic [DATA_BITS-1:0]     node_hit_data,
  output logic [INDEX_BITS:0]      used_count,
  output logic                     full,
  output logic                     empty
);

  localparam logic [INDEX_BITS:0] CAP = {1'b1, {INDEX_BITS{1'b0}}};

  ctrl_state_e           state_q, state_d;
  req_op_e               op_q, op_d;
  logic [KEYS_BITS-1:0]  key_q, key_d;
  logic [DATA_BITS-1:0]  data_q, data_d;
  logic                  found_q, found_d;
  logic [INDEX_BITS-1:0] pos_q, pos_d;
  logic [DATA_BITS-1:0]  hit_data_q, hit_data_d;
  rsp_status_e           status_q, status_d;
  logic [DATA_BITS-1:0]  rsp_data_q, rsp_data_d;
  logic [INDEX_BITS:0]   used_q, used_d;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= S_INIT;
      op_q       <= OP_LOOKUP;
      key_q      <= '0;
      data_q     <= '0;
      found_q    <= 1'b0;
      pos_q      <= '0;
      hit_data_q <= '0;
      status_q   <= RSP_OK;
      rsp_data_q <= '0;
      used_q     <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      key_q      <= key_d;
      data_q     <= data_d;
      found_q    <= found_d;
      pos_q      <= pos_d;
      hit_data_q <= hit_data_d;
      status_q   <= status_d;
      rsp_data_q <= rsp_data_d;
      used_q     <= used_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    key_d      = key_q;
    data_d     = data_q;
    found_d    = found_q;
    pos_d      = pos_q;
    hit_data_d = hit_data_q;
    status_d   = status_q;
    rsp_data_d = rsp_data_q;
    used_d     = used_q;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    node_cmd   = '0;
    node_key   = '0;
    node_pos   = '0;
    node_data  = '0;

    case (state_q)
      S_INIT: begin
        // INIT is also the held state while reset is low; only command once released.
        if (reset) node_cmd = NODE_CMD_BITS'(CMD_RESET);
        used_d  = '0;
        state_d = S_IDLE;
      end
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          op_d       = req_op_e'(req_op);
          key_d      = req_key;
          data_d     = req_data;
          status_d   = RSP_OK;
          rsp_data_d = '0;
          state_d    = S_WAIT;
          // Reserved ops ride the same WAIT/DECIDE path so latency stays uniform.
          if (req_op_e'(req_op) != OP_RSVD) begin
            node_cmd = NODE_CMD_BITS'(CMD_FIND);
            node_key = req_key;
          end
        end
      end
      S_WAIT: begin
        found_d    = node_found;
        pos_d      = node_hit_pos;
        hit_data_d = node_hit_data;
        state_d    = S_DECIDE;
      end
      S_DECIDE: begin
        state_d = S_RESP;
        case (op_q)
          OP_LOOKUP: begin
            if (found_q) begin
              status_d   = RSP_OK;
              rsp_data_d = hit_data_q;
            end else begin
              status_d = RSP_NOT_FOUND;
            end
          end
          OP_INSERT: begin
            if (found_q) begin
              status_d = RSP_UPDATED;
              state_d  = S_WRITE;
            end else if (used_q == CAP) begin
              status_d = RSP_FULL;
            end else begin
              status_d = RSP_OK;
              used_d   = used_q + (INDEX_BITS+1)'(1);
              state_d  = S_SHIFT;
            end
          end
          OP_DELETE: begin
            if (found_q) begin
              status_d   = RSP_OK;
              rsp_data_d = hit_data_q;
              used_d     = used_q - (INDEX_BITS+1)'(1);
              state_d    = S_SHIFT;
            end else begin
              status_d = RSP_NOT_FOUND;
            end
          end
          default: status_d = RSP_BADOP;
        endcase
      end
      S_SHIFT: begin
        node_pos = pos_q;
        if (op_q == OP_INSERT) begin
          node_cmd = NODE_CMD_BITS'(CMD_SHIFT_UP);
          state_d  = S_WRITE;
        end else begin
          node_cmd = NODE_CMD_BITS'(CMD_SHIFT_DOWN);
          state_d  = S_RESP;
        end
      end
      S_WRITE: begin
        node_cmd  = NODE_CMD_BITS'(CMD_WRITE);
        node_pos  = pos_q;
        node_key  = key_q;
        node_data = data_q;
        state_d   = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase
  end

  assign rsp_status = status_q;
  assign rsp_data   = rsp_data_q;
  assign used_count = used_q;
  assign full       = (used_q == CAP);
  assign empty      = (used_q == '0);

endmodule

// File: tb/tb_zesal_node_ctrl.sv
// Directed bench for zesal_node_ctrl: drives requests against a scripted node
// response and checks command sequence, latency, response and occupancy.
module tb_zesal_node_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       req_valid, req_ready;
  logic [1:0] req_op;
  logic [7:0] req_key, req_data;
  logic       rsp_valid, rsp_ready;
  logic [2:0] rsp_status;
  logic [7:0] rsp_data;
  logic [7:0] node_cmd, node_key, node_pos, node_data;
  logic       node_found;
  logic [7:0] node_hit_pos, node_hit_data;
  logic [8:0] used_count;
  logic       full, empty;

  int n_vec = 0;
  int n_bad = 0;

  logic [15:0] cmd_log;
  logic [7:0]  sh_pos, wr_pos, wr_key, wr_data;

  always #5 clock = ~clock;

  zesal_node_ctrl dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_key(req_key), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_status(rsp_status), .rsp_data(rsp_data),
    .node_cmd(node_cmd), .node_key(node_key), .node_pos(node_pos),
    .node_data(node_data), .node_found(node_found),
    .node_hit_pos(node_hit_pos), .node_hit_data(node_hit_data),
    .used_count(used_count), .full(full), .empty(empty)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Wait for the next falling edge and log any non-idle node command.
  task automatic sample_neg();
    @(negedge clock);
    if (node_cmd != 8'd0) begin
      cmd_log = {cmd_log[11:0], node_cmd[3:0]};
      if (node_cmd == 8'd4 || node_cmd == 8'd5) sh_pos = node_pos;
      if (node_cmd == 8'd6) begin
        wr_pos  = node_pos;
        wr_key  = node_key;
        wr_data = node_data;
      end
    end
  endtask

  // Entered and left at posedge+1 with the controller in IDLE.
  task automatic run_req(input string tag, input logic [1:0] op, input logic [7:0] key,
                         input logic [7:0] dat, input logic mf, input logic [7:0] mpos,
                         input logic [7:0] mdat, input logic [2:0] est, input logic [7:0] edat,
                         input int elat, input logic [15:0] ecmd, input logic [8:0] eused,
                         input int hold);
    int lat;
    logic [3:0] nib;
    logic has_sh, has_wr;
    check({tag, "_ready"}, req_ready, 1);
    cmd_log = '0; sh_pos = 'x; wr_pos = 'x; wr_key = 'x; wr_data = 'x;
    req_valid = 1'b1; req_op = op; req_key = key; req_data = dat;
    node_found = mf; node_hit_pos = mpos; node_hit_data = mdat;
    rsp_ready = (hold == 0);
    sample_neg();
    @(posedge clock); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 12) begin
      sample_neg();
      lat++;
    end
    check({tag, "_lat"}, lat, elat);
    check({tag, "_status"}, rsp_status, est);
    check({tag, "_data"}, rsp_data, edat);
    for (int i = 0; i < hold; i++) begin
      sample_neg();
      check({tag, "_hold_valid"}, rsp_valid, 1);
      check({tag, "_hold_status"}, rsp_status, est);
      check({tag, "_hold_data"}, rsp_data, edat);
      check({tag, "_hold_ready"}, req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clock); #1;
    check({tag, "_rsp_drop"}, rsp_valid, 0);
    check({tag, "_cmds"}, cmd_log, ecmd);
    check({tag, "_used"}, used_count, eused);
    has_sh = 1'b0; has_wr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      nib = ecmd[i*4 +: 4];
      if (nib == 4'd4 || nib == 4'd5) has_sh = 1'b1;
      if (nib == 4'd6) has_wr = 1'b1;
    end
    if (has_sh) check({tag, "_sh_pos"}, sh_pos, mpos);
    if (has_wr) begin
      check({tag, "_wr_pos"}, wr_pos, mpos);
      check({tag, "_wr_key"}, wr_key, key);
      check({tag, "_wr_data"}, wr_data, dat);
    end
  endtask

  initial begin
    int waited;
    reset = 1'b0; req_valid = 1'b0; req_op = '0; req_key = '0; req_data = '0;
    rsp_ready = 1'b1; node_found = 1'b0; node_hit_pos = '0; node_hit_data = '0;

    repeat (2) @(posedge clock);
    #1;
    check("rst_cmd", node_cmd, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_used", used_count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    reset = 1'b1;
    #1;
    check("init_cmd", node_cmd, 1);
    check("init_req_ready", req_ready, 0);
    @(posedge clock); #1;
    check("idle_cmd", node_cmd, 0);
    check("idle_req_ready", req_ready, 1);
    check("idle_empty", empty, 1);

    //       tag        op    key    data   f  pos    hdat   st  rdata lat cmds      used hold
    run_req("ins_new",  2'd1, 8'h10, 8'hAA, 0, 8'h00, 8'h00, 0, 8'h00, 5, 16'h0246, 1, 0);
    check("one_empty", empty, 0);
    run_req("lkp_hit",  2'd0, 8'h10, 8'h00, 1, 8'h00, 8'hAA, 0, 8'hAA, 3, 16'h0002, 1, 0);
    run_req("lkp_miss", 2'd0, 8'h22, 8'h00, 0, 8'h01, 8'h00, 1, 8'h00, 3, 16'h0002, 1, 0);
    run_req("ins_upd",  2'd1, 8'h10, 8'hBB, 1, 8'h00, 8'hAA, 3, 8'h00, 4, 16'h0026, 1, 0);
    run_req("del_hit",  2'd2, 8'h10, 8'h00, 1, 8'h03, 8'hBB, 0, 8'hBB, 4, 16'h0025, 0, 0);
    run_req("del_miss", 2'd2, 8'h55, 8'h00, 0, 8'h00, 8'h00, 1, 8'h00, 3, 16'h0002, 0, 0);
    run_req("badop",    2'd3, 8'h11, 8'h00, 1, 8'h00, 8'h99, 4, 8'h00, 3, 16'h0000, 0, 0);
    run_req("hold",     2'd0, 8'h33, 8'h00, 1, 8'h02, 8'h5A, 0, 8'h5A, 3, 16'h0002, 0, 5);

    for (int i = 0; i < 256; i++)
      run_req("fill", 2'd1, 8'(i), 8'(i ^ 8'h3C), 0, 8'(i), 8'h00, 0, 8'h00, 5, 16'h0246,
              9'(i + 1), 0);
    check("fill_full", full, 1);
    check("fill_empty", empty, 0);
    run_req("ins_full", 2'd1, 8'hF0, 8'h01, 0, 8'h04, 8'h00, 2, 8'h00, 3, 16'h0002, 256, 0);
    run_req("del_full", 2'd2, 8'h07, 8'h00, 1, 8'h07, 8'h77, 0, 8'h77, 4, 16'h0025, 255, 0);
    check("del_not_full", full, 0);

    // Reset landing while ShiftUp is on the node bus.
    req_valid = 1'b1; req_op = 2'd1; req_key = 8'h44; req_data = 8'h66;
    node_found = 1'b0; node_hit_pos = 8'h05;
    @(posedge clock); #1;
    req_valid = 1'b0;
    waited = 0;
    do begin
      @(negedge clock);
      waited++;
    end while (node_cmd != 8'd4 && waited < 10);
    check("mid_shift_seen", node_cmd, 4);
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    check("mid_rst_cmd", node_cmd, 1);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_req_ready", req_ready, 0);
    check("mid_rst_used", used_count, 0);
    @(posedge clock); #1;
    check("mid_idle_cmd", node_cmd, 0);
    check("mid_idle_ready", req_ready, 1);
    run_req("post_rst", 2'd0, 8'h44, 8'h00, 0, 8'h00, 8'h00, 1, 8'h00, 3, 16'h0002, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
